// File: rtl/spi_cmd_regfile.sv
// Command decoder and register file behind an SPI slave byte engine.
// Decodes framed read/write commands into an NREGS x 8-bit bank and supplies the next TX byte.
module spi_cmd_regfile #(
  parameter int unsigned NREGS = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_start,
  input  logic              msg_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic [NREGS*8-1:0] reg_out,
  output logic              wr_strobe,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {StIdle, StCmd, StWrite, StRead, StDiscard} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [NREGS-1:0][7:0]   regs_q, regs_d;
  logic [7:0]              tx_q, tx_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic [7:0]              frame_q, frame_d;
  logic [7:0]              err_q, err_d;

  logic [7:0]              err_inc;
  logic [6:0]              rsvd_bits;
  logic [AW-1:0]           addr_inc;
  logic [AW-1:0]           cmd_addr;

  assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign rsvd_bits = rx_data[6:0] >> AW;
  assign addr_inc  = addr_q + 1'b1;
  assign cmd_addr  = rx_data[AW-1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_d     = frame_q;
    err_d       = err_q;

    if (msg_start) begin
      // Start wins over a coincident byte or end marker; a coincident byte counts as an error.
      state_d = StCmd;
      tx_d    = frame_q;
      if (rx_valid) err_d = err_inc;
    end else begin
      if (rx_valid) begin
        unique case (state_q)
          StIdle: err_d = err_inc;
          StCmd: begin
            if (rsvd_bits != 7'd0) begin
              state_d = StDiscard;
              err_d   = err_inc;
              tx_d    = 8'hFF;
            end else begin
              addr_d = cmd_addr;
              if (rx_data[7]) begin
                state_d = StWrite;
                tx_d    = rx_data;
              end else begin
                state_d = StRead;
                tx_d    = regs_q[cmd_addr];
              end
            end
          end
          StWrite: begin
            regs_d[addr_q] = rx_data;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
            wr_data_d      = rx_data;
            addr_d         = addr_inc;
            tx_d           = rx_data;
          end
          StRead: begin
            addr_d = addr_inc;
            tx_d   = regs_q[addr_inc];
          end
          StDiscard: tx_d = 8'hFF;
          default: state_d = StIdle;
        endcase
      end
      // End is applied after any same-cycle byte has been processed.
      if (msg_end) begin
        if (state_d == StWrite || state_d == StRead) frame_d = frame_q + 8'd1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      regs_q      <= '0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      frame_q     <= 8'h00;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = tx_q;
  assign reg_out   = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_cnt = frame_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: scoreboard queues for TX bytes and register writes.
module tb_spi_cmd_regfile;

  localparam int unsigned NREGS = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              msg_start = 1'b0;
  logic              msg_end = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [7:0]        tx_data;
  logic [NREGS*8-1:0] reg_out;
  logic              wr_strobe;
  logic [3:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        frame_cnt;
  logic [7:0]        err_cnt;

  spi_cmd_regfile #(.NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_start (msg_start),
    .msg_end   (msg_end),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .reg_out   (reg_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_exp_q[$];
  logic [11:0] wr_exp_q[$];  // {addr, data}

  logic [7:0] m_regs [NREGS];
  logic [7:0] m_frame;
  logic [7:0] m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      if (wr_exp_q.size() == 0) check("wr_unexpected", {20'd0, wr_addr, wr_data}, 32'd0);
      else check("wr", {20'd0, wr_addr, wr_data}, {20'd0, wr_exp_q.pop_front()});
    end
  end

  task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] d);
    @(negedge clk);
    msg_start = s; msg_end = e; rx_valid = v; rx_data = d;
    @(negedge clk);
    msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0;
    if (tx_exp_q.size() > 0) check("tx", tx_data, tx_exp_q.pop_front());
  endtask

  task automatic start_msg();
    tx_exp_q.push_back(m_frame);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp_tx);
    tx_exp_q.push_back(exp_tx);
    drive(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic send_wr(input logic [3:0] a, input logic [7:0] d);
    wr_exp_q.push_back({a, d});
    m_regs[a] = d;
    send(d, d);
  endtask

  task automatic end_msg();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_frame = 8'h00;
    m_err   = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) check(tag, reg_out[8*i +: 8], m_regs[i]);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tx", tx_data, 8'h00);
    check("rst_regs", reg_out, '0);
    check("rst_wr", {wr_strobe, wr_addr, wr_data}, 13'd0);
    check("rst_cnt", {frame_cnt, err_cnt}, 16'd0);
    rst_n = 1'b1;

    // Write frame 0x82,0x11,0x22,0x33.
    start_msg();
    send(8'h82, 8'h82);
    send_wr(4'd2, 8'h11);
    send_wr(4'd3, 8'h22);
    send_wr(4'd4, 8'h33);
    end_msg();
    m_frame++;
    check("wr_frame_cnt", frame_cnt, m_frame);
    check_regs("wr_regs");

    // Preload reg15/reg0 with a wrapping write, then read with wrap.
    start_msg();
    send(8'h8F, 8'h8F);
    send_wr(4'd15, 8'hAB);
    send_wr(4'd0, 8'hCD);
    end_msg();
    m_frame++;
    start_msg();
    send(8'h0F, 8'hAB);
    send(8'h00, 8'hCD);
    send(8'h00, m_regs[1]);
    end_msg();
    m_frame++;
    check("rd_frame_cnt", frame_cnt, m_frame);
    check_regs("rd_regs");

    // Reserved bits set: discard.
    start_msg();
    send(8'h40, 8'hFF);
    m_err++;
    send(8'h55, 8'hFF);
    end_msg();
    check("rsvd_err", err_cnt, m_err);
    check("rsvd_frame", frame_cnt, m_frame);
    check_regs("rsvd_regs");

    // Start with coincident byte, then last byte with end.
    tx_exp_q.push_back(m_frame);
    drive(1'b1, 1'b0, 1'b1, 8'h99);
    m_err++;
    check("coll_start_err", err_cnt, m_err);
    send(8'h81, 8'h81);
    wr_exp_q.push_back({4'd1, 8'h5A});
    m_regs[1] = 8'h5A;
    tx_exp_q.push_back(8'h5A);
    drive(1'b0, 1'b1, 1'b1, 8'h5A);
    m_frame++;
    check("coll_end_frame", frame_cnt, m_frame);
    check_regs("coll_end_regs");

    // Byte in idle: error only, tx unchanged.
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    m_err++;
    check("idle_err", err_cnt, m_err);
    check("idle_tx", tx_data, 8'h5A);

    // Start with end: frame aborted and not counted, earlier write persists.
    start_msg();
    send(8'h83, 8'h83);
    send_wr(4'd3, 8'h01);
    tx_exp_q.push_back(m_frame);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    end_msg();
    check("startend_frame", frame_cnt, m_frame);
    check_regs("startend_regs");

    // Mid-frame reset.
    start_msg();
    send(8'h84, 8'h84);
    send_wr(4'd4, 8'h42);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_tx", tx_data, 8'h00);
    check("mrst_regs", reg_out, '0);
    check("mrst_wr", {wr_strobe, wr_addr, wr_data}, 13'd0);
    check("mrst_cnt", {frame_cnt, err_cnt}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_msg();
    send(8'h85, 8'h85);
    send_wr(4'd5, 8'h66);
    end_msg();
    m_frame++;
    check("post_rst_frame", frame_cnt, m_frame);
    check_regs("post_rst_regs");

    // Error saturation.
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, 8'(i));
    check("err_sat", err_cnt, 8'hFF);

    // Frame counter wrap over 257 read frames.
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 8'h05);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      m_frame++;
    end
    check("frame_wrap", frame_cnt, m_frame);
    check("err_hold", err_cnt, 8'hFF);

    check("wr_pending", wr_exp_q.size(), 0);
    check("tx_pending", tx_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_regfile.md
# spi_cmd_regfile

Command decoder and register file placed directly downstream of the SPI slave byte engine. It consumes received bytes and message start/end markers, decodes framed read/write commands into an NREGS x 8-bit register bank, and supplies the byte the SPI slave shifts out on each next byte slot. The register bank is exported flat to the rest of the fabric, together with a per-write strobe.

## Interface
- NREGS, 16: number of 8-bit registers. Power of two, range 2..16. AW = log2(NREGS).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- msg_start  in  1  one-cycle pulse at message start (SSEL falling edge, already synchronized).
- msg_end  in  1  one-cycle pulse at message end (SSEL rising edge).
- rx_valid  in  1  one-cycle pulse; a complete byte is on rx_data.
- rx_data  in  8  received byte, MSB-first assembled, valid with rx_valid.
- tx_data  out  8  byte the SPI slave loads at the next byte boundary; registered.
- reg_out  out  NREGS*8  register bank; reg i occupies bits [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse per register write.
- wr_addr  out  AW  address of the write flagged by wr_strobe.
- wr_data  out  8  data of the write flagged by wr_strobe.
- frame_cnt  out  8  completed valid frames, modulo 256.
- err_cnt  out  8  protocol errors, saturating at 8'hFF.

## Operation
- Frame format: byte0 is the command byte.
  - bit7: 1 = write, 0 = read.
  - bits[6:AW]: reserved, must be 0.
  - bits[AW-1:0]: start address.
  - Bytes 1..n are data bytes. The address increments after each data byte, wrapping modulo NREGS.
- States: IDLE, CMD, WRITE, READ, DISCARD.
  - Any state + msg_start -> CMD.
  - CMD + rx_valid: reserved bits nonzero -> DISCARD, err_cnt+1. Otherwise addr <= bits[AW-1:0] and state -> WRITE (bit7=1) or READ (bit7=0).
  - WRITE + rx_valid: reg[addr] <= rx_data; wr_strobe=1, wr_addr=addr, wr_data=rx_data; addr+1.
  - READ + rx_valid: addr+1; registers unchanged.
  - DISCARD + rx_valid: ignored.
  - IDLE + rx_valid: byte outside a message; err_cnt+1, otherwise ignored.
  - msg_end from WRITE or READ: frame_cnt+1, then IDLE.
  - msg_end from CMD or DISCARD: frame_cnt unchanged, then IDLE.
  - msg_end in IDLE: no effect.
- tx_data selection, registered, computed from the next state:
  - Entering CMD: frame_cnt (value before this message).
  - READ: reg[addr_next], where addr_next is the start address after the command byte, or the incremented address after a data byte.
  - WRITE: echo of the rx_data just received.
  - DISCARD: 8'hFF.
  - IDLE: unchanged.
- Simultaneous events:
  - msg_start with rx_valid: msg_start wins. The byte is dropped and err_cnt+1.
  - msg_end with rx_valid: the byte is processed first (write/increment), then IDLE. frame_cnt increments if the state after processing is WRITE or READ.
  - msg_start with msg_end: msg_start wins. The ending frame is not counted.
- A msg_start mid-frame aborts that frame. Writes already done persist.
- Reset (any time, including mid-frame) has these values:
  - state IDLE, addr 0, all registers 8'h00.
  - tx_data 8'h00, wr_strobe 0, wr_addr 0, wr_data 8'h00.
  - frame_cnt 0, err_cnt 0.

## Timing
- All outputs are registered. Latency is 1 clk from an input pulse to the effect on any output.
- reg_out, wr_* and tx_data update on the clk edge after rx_valid is sampled.
- tx_data is stable at least 1 clk before the upstream slave's next byte-boundary load. The slave's edge synchronizer provides ≥2 clk of slack per SCK half-period, given clk ≥ 8x SCK.
- wr_strobe is exactly 1 clk wide. There is one strobe per written byte, and none on read, CMD or discarded bytes.
- Back-to-back rx_valid on consecutive cycles is handled without loss.

## Test plan
- Write frame: start, bytes 0x82,0x11,0x22,0x33, end -> reg2=0x11, reg3=0x22, reg4=0x33; three wr_strobe pulses (addr 2,3,4); frame_cnt=1; tx_data sequence 0x00, 0x82... echo (0x11, 0x22, 0x33).
- Read with wrap (NREGS=16): preload reg15=0xAB, reg0=0xCD; start, 0x0F, two dummies, end -> tx_data after cmd=0xAB, then 0xCD; no wr_strobe; frame_cnt+1.
- Reserved bits: start, 0x40, 0x55, end -> err_cnt=1, tx_data=0xFF, no writes, frame_cnt unchanged.
- Collisions: rx_valid with msg_start -> byte dropped, err_cnt+1. Last data byte with msg_end -> write lands, frame_cnt+1. rx_valid in IDLE -> err_cnt+1.
- Mid-frame reset: assert rst_n low during a WRITE frame -> all outputs at reset values immediately; the next valid frame works normally.
- Saturation: 300 IDLE bytes -> err_cnt=0xFF. 257 valid frames -> frame_cnt=0x01.
